// File: rtl/inc_seq_checker.sv
// Purpose: monitors a modulo-N enable-gated counter, predicts each count, tallies wraps and offences.
// Latency: a count sampled at a clock edge is reflected on wrap/error/err_count right after that edge.
// Backpressure: none; a passive observer that samples every cycle and never stalls the counter.
module inc_seq_checker #(
  parameter int N      = 8,
  parameter int WRAP_W = 16,
  parameter int ERR_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       count,
  input  logic              enable,
  input  logic              clear,
  output logic              wrap,
  output logic [WRAP_W-1:0] wraps,
  output logic              error,
  output logic [ERR_W-1:0]  err_count,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // 17-bit constants so that N=65536 remains representable
  localparam logic [16:0] LAST  = 17'(N - 1);
  localparam logic [16:0] LIMIT = 17'(N);

  state_t      cur_state;
  state_t      nxt_state;
  logic [15:0] prev_count;
  logic        prev_en;
  logic [16:0] prev_ext;
  logic [16:0] count_ext;
  logic [16:0] exp_count;
  logic        checking;
  logic        offence;
  logic        wrap_seen;

  assign prev_ext  = {1'b0, prev_count};
  assign count_ext = {1'b0, count};
  assign state     = cur_state;

  // Predict this cycle's count from last cycle's sample and classify it
  always_comb begin
    exp_count = prev_ext;
    if (prev_en) begin
      exp_count = (prev_ext == LAST) ? 17'd0 : prev_ext + 17'd1;
    end
    checking  = (cur_state == TRACK) || (cur_state == FAULT);
    offence   = checking && ((count_ext != exp_count) || (count_ext >= LIMIT));
    wrap_seen = checking && prev_en && (prev_ext == LAST) && (count == 16'd0);
  end

  // Next-state logic; clear always forces a resync cycle
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      SYNC:    nxt_state = TRACK;
      TRACK:   nxt_state = offence ? FAULT : TRACK;
      FAULT:   nxt_state = FAULT;
      default: nxt_state = SYNC;
    endcase
    if (clear) begin
      nxt_state = SYNC;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_state <= SYNC;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Sample the monitored counter every cycle, whatever the state; prediction resyncs from it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_count <= 16'd0;
      prev_en    <= 1'b0;
    end else begin
      prev_count <= count;
      prev_en    <= enable;
    end
  end

  // Wrap pulse, sticky error and saturating statistics; clear wins over everything
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrap      <= 1'b0;
      wraps     <= '0;
      error     <= 1'b0;
      err_count <= '0;
    end else if (clear) begin
      wrap      <= 1'b0;
      wraps     <= '0;
      error     <= 1'b0;
      err_count <= '0;
    end else begin
      wrap <= wrap_seen;
      if (wrap_seen && (wraps != '1)) begin
        wraps <= wraps + WRAP_W'(1);
      end
      if (offence) begin
        error <= 1'b1;
        if (err_count != '1) begin
          err_count <= err_count + ERR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_inc_seq_checker.sv
// Directed bench for inc_seq_checker: three instances (N=8, N=8 with 2-bit err_count, N=65536).
// The bench plays the role of the monitored counter, driving count/enable after each rising edge.
// Outputs are sampled 1 time unit after the rising edge.
module tb_inc_seq_checker;

  logic        clock = 1'b0;
  logic        reset;

  logic [15:0] count_a, count_s, count_b;
  logic        enable_a, enable_s, enable_b;
  logic        clear_a, clear_s, clear_b;

  logic        wrap_a, wrap_s, wrap_b;
  logic [15:0] wraps_a, wraps_s, wraps_b;
  logic        error_a, error_s, error_b;
  logic [7:0]  err_count_a, err_count_b;
  logic [1:0]  err_count_s;
  logic [1:0]  state_a, state_s, state_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  inc_seq_checker #(.N(8), .WRAP_W(16), .ERR_W(8)) dut (
    .clock(clock), .reset(reset), .count(count_a), .enable(enable_a), .clear(clear_a),
    .wrap(wrap_a), .wraps(wraps_a), .error(error_a), .err_count(err_count_a), .state(state_a)
  );

  inc_seq_checker #(.N(8), .WRAP_W(16), .ERR_W(2)) dut_sat (
    .clock(clock), .reset(reset), .count(count_s), .enable(enable_s), .clear(clear_s),
    .wrap(wrap_s), .wraps(wraps_s), .error(error_s), .err_count(err_count_s), .state(state_s)
  );

  inc_seq_checker #(.N(65536), .WRAP_W(16), .ERR_W(8)) dut_big (
    .clock(clock), .reset(reset), .count(count_b), .enable(enable_b), .clear(clear_b),
    .wrap(wrap_b), .wraps(wraps_b), .error(error_b), .err_count(err_count_b), .state(state_b)
  );

  task automatic tick_a(input logic [15:0] c, input logic e, input logic clr);
    count_a = c; enable_a = e; clear_a = clr;
    @(posedge clock); #1;
  endtask

  task automatic tick_s(input logic [15:0] c, input logic e);
    count_s = c; enable_s = e;
    @(posedge clock); #1;
  endtask

  task automatic tick_b(input logic [15:0] c, input logic e, input logic clr);
    count_b = c; enable_b = e; clear_b = clr;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    count_a = 16'd0; enable_a = 1'b1; clear_a = 1'b0;
    count_s = 16'd0; enable_s = 1'b0; clear_s = 1'b0;
    count_b = 16'd0; enable_b = 1'b0; clear_b = 1'b0;
    #12;
    vectors++; if (state_a !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state_a); end
    vectors++; if (wrap_a !== 1'b0) begin miscompares++; $display("FAIL reset_wrap: got %0d expected 0", wrap_a); end
    vectors++; if (wraps_a !== 16'd0) begin miscompares++; $display("FAIL reset_wraps: got %0d expected 0", wraps_a); end
    vectors++; if (error_a !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %0d expected 0", error_a); end
    vectors++; if (err_count_a !== 8'd0) begin miscompares++; $display("FAIL reset_err_count: got %0d expected 0", err_count_a); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  // 20 enabled clocks: 0..7,0..7,0..3 -> two wraps, no error
  task automatic test_count_run;
    logic exp_w;
    for (int j = 1; j <= 20; j++) begin
      tick_a(16'((j - 1) % 8), 1'b1, 1'b0);
      exp_w = (j == 9) || (j == 17);
      vectors++;
      if (wrap_a !== exp_w) begin miscompares++; $display("FAIL run_wrap[%0d]: got %0d expected %0d", j, wrap_a, exp_w); end
      if (j == 1) begin
        vectors++; if (state_a !== 2'd1) begin miscompares++; $display("FAIL run_sync_exit: got %0d expected 1", state_a); end
      end
    end
    vectors++; if (wraps_a !== 16'd2) begin miscompares++; $display("FAIL run_wraps: got %0d expected 2", wraps_a); end
    vectors++; if (error_a !== 1'b0) begin miscompares++; $display("FAIL run_error: got %0d expected 0", error_a); end
    vectors++; if (state_a !== 2'd1) begin miscompares++; $display("FAIL run_state: got %0d expected 1", state_a); end
  endtask

  // Count held while enable is low is legal; it moves again once enable returns
  task automatic test_enable_gating;
    logic [15:0] cv [4] = '{16'd4, 16'd4, 16'd4, 16'd5};
    logic        ev [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      tick_a(cv[i], ev[i], 1'b0);
      vectors++; if (error_a !== 1'b0) begin miscompares++; $display("FAIL gate_error[%0d]: got %0d expected 0", i, error_a); end
      vectors++; if (wrap_a !== 1'b0) begin miscompares++; $display("FAIL gate_wrap[%0d]: got %0d expected 0", i, wrap_a); end
    end
  endtask

  // 5 -> 7 skip is one offence; legal continuation (including a wrap in FAULT) adds none
  task automatic test_skip;
    tick_a(16'd7, 1'b1, 1'b0);
    vectors++; if (error_a !== 1'b1) begin miscompares++; $display("FAIL skip_error: got %0d expected 1", error_a); end
    vectors++; if (err_count_a !== 8'd1) begin miscompares++; $display("FAIL skip_err_count: got %0d expected 1", err_count_a); end
    vectors++; if (state_a !== 2'd2) begin miscompares++; $display("FAIL skip_state: got %0d expected 2", state_a); end
    tick_a(16'd0, 1'b1, 1'b0);
    vectors++; if (wraps_a !== 16'd3) begin miscompares++; $display("FAIL skip_fault_wraps: got %0d expected 3", wraps_a); end
    tick_a(16'd1, 1'b1, 1'b0);
    tick_a(16'd2, 1'b1, 1'b0);
    vectors++; if (err_count_a !== 8'd1) begin miscompares++; $display("FAIL skip_err_hold: got %0d expected 1", err_count_a); end
    vectors++; if (state_a !== 2'd2) begin miscompares++; $display("FAIL skip_state_hold: got %0d expected 2", state_a); end
  endtask

  // Out-of-range count for 3 cycles, then clear back to SYNC and TRACK
  task automatic test_range_and_clear;
    for (int i = 0; i < 3; i++) begin
      tick_a(16'd9, 1'b1, 1'b0);
      vectors++;
      if (err_count_a !== 8'(2 + i)) begin miscompares++; $display("FAIL range_err_count[%0d]: got %0d expected %0d", i, err_count_a, 2 + i); end
    end
    tick_a(16'd3, 1'b1, 1'b1);
    vectors++; if (state_a !== 2'd0) begin miscompares++; $display("FAIL clear_state: got %0d expected 0", state_a); end
    vectors++; if (error_a !== 1'b0) begin miscompares++; $display("FAIL clear_error: got %0d expected 0", error_a); end
    vectors++; if (err_count_a !== 8'd0) begin miscompares++; $display("FAIL clear_err_count: got %0d expected 0", err_count_a); end
    vectors++; if (wraps_a !== 16'd0) begin miscompares++; $display("FAIL clear_wraps: got %0d expected 0", wraps_a); end
    vectors++; if (wrap_a !== 1'b0) begin miscompares++; $display("FAIL clear_wrap: got %0d expected 0", wrap_a); end
    tick_a(16'd4, 1'b1, 1'b0);
    vectors++; if (state_a !== 2'd1) begin miscompares++; $display("FAIL clear_resync: got %0d expected 1", state_a); end
    tick_a(16'd5, 1'b1, 1'b0);
    vectors++; if (error_a !== 1'b0) begin miscompares++; $display("FAIL clear_track_error: got %0d expected 0", error_a); end
  endtask

  // Asynchronous reset mid-count, then the counter restarts at 0 without being flagged
  task automatic test_reset_midrun;
    tick_a(16'd6, 1'b1, 1'b0);
    tick_a(16'd7, 1'b1, 1'b0);
    tick_a(16'd0, 1'b1, 1'b0);
    vectors++; if (wraps_a !== 16'd1) begin miscompares++; $display("FAIL mid_wraps: got %0d expected 1", wraps_a); end
    tick_a(16'd1, 1'b1, 1'b0);
    tick_a(16'd2, 1'b1, 1'b0);
    tick_a(16'd5, 1'b1, 1'b0);
    vectors++; if (err_count_a !== 8'd1) begin miscompares++; $display("FAIL mid_err_count: got %0d expected 1", err_count_a); end
    tick_a(16'd6, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    vectors++; if (state_a !== 2'd0) begin miscompares++; $display("FAIL async_state: got %0d expected 0", state_a); end
    vectors++; if (wraps_a !== 16'd0) begin miscompares++; $display("FAIL async_wraps: got %0d expected 0", wraps_a); end
    vectors++; if (error_a !== 1'b0) begin miscompares++; $display("FAIL async_error: got %0d expected 0", error_a); end
    vectors++; if (err_count_a !== 8'd0) begin miscompares++; $display("FAIL async_err_count: got %0d expected 0", err_count_a); end
    tick_a(16'd0, 1'b1, 1'b0);
    tick_a(16'd0, 1'b1, 1'b0);
    vectors++; if (state_a !== 2'd0) begin miscompares++; $display("FAIL held_reset_state: got %0d expected 0", state_a); end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_a(16'(i), 1'b1, 1'b0);
    end
    vectors++; if (error_a !== 1'b0) begin miscompares++; $display("FAIL restart_error: got %0d expected 0", error_a); end
    vectors++; if (state_a !== 2'd1) begin miscompares++; $display("FAIL restart_state: got %0d expected 1", state_a); end
  endtask

  // Narrow err_count: five offences saturate at 3
  task automatic test_saturation;
    int exp_e;
    for (int i = 1; i <= 5; i++) begin
      tick_s(16'(i % 2), 1'b0);
      exp_e = (i > 3) ? 3 : i;
      vectors++;
      if (err_count_s !== 2'(exp_e)) begin miscompares++; $display("FAIL sat_err_count[%0d]: got %0d expected %0d", i, err_count_s, exp_e); end
    end
    vectors++; if (state_s !== 2'd2) begin miscompares++; $display("FAIL sat_state: got %0d expected 2", state_s); end
  endtask

  // Full 16-bit modulus: 65535 -> 0 is a legal wrap
  task automatic test_wide_wrap;
    tick_b(16'd65533, 1'b0, 1'b1);
    vectors++; if (state_b !== 2'd0) begin miscompares++; $display("FAIL wide_clear_state: got %0d expected 0", state_b); end
    tick_b(16'd65533, 1'b1, 1'b0);
    tick_b(16'd65534, 1'b1, 1'b0);
    tick_b(16'd65535, 1'b1, 1'b0);
    vectors++; if (wrap_b !== 1'b0) begin miscompares++; $display("FAIL wide_prewrap: got %0d expected 0", wrap_b); end
    tick_b(16'd0, 1'b1, 1'b0);
    vectors++; if (wrap_b !== 1'b1) begin miscompares++; $display("FAIL wide_wrap: got %0d expected 1", wrap_b); end
    vectors++; if (wraps_b !== 16'd1) begin miscompares++; $display("FAIL wide_wraps: got %0d expected 1", wraps_b); end
    vectors++; if (error_b !== 1'b0) begin miscompares++; $display("FAIL wide_error: got %0d expected 0", error_b); end
    tick_b(16'd1, 1'b1, 1'b0);
    vectors++; if (wrap_b !== 1'b0) begin miscompares++; $display("FAIL wide_wrap_pulse: got %0d expected 0", wrap_b); end
    vectors++; if (err_count_b !== 8'd0) begin miscompares++; $display("FAIL wide_err_count: got %0d expected 0", err_count_b); end
  endtask

  initial begin
    test_reset;
    test_count_run;
    test_enable_gating;
    test_skip;
    test_range_and_clear;
    test_reset_midrun;
    test_saturation;
    test_wide_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
